cpu_run_checker: RTL and testbench

- Synthesizable, parametrised run monitor for the single-cycle CPU. It replaces ad-hoc pass/fail loops in benches and can also sit on an FPGA next to the core.
- Watches the instruction-fetch address and the debug register read port. Decides PASS/FAIL against a programmable set of expected values, with timeout and hang detection.
- Adds match modes (any-of / ordered sequence), a cycle counter, and sticky result reporting.

---
 rtl/cpu_run_checker_pkg.sv | 34 +++
 rtl/cpu_run_checker_matcher.sv | 43 ++++
 rtl/cpu_run_checker.sv | 177 +++++++++++++++++
 tb/tb_cpu_run_checker.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_checker_pkg.sv
// ============================================================================
// Module   : cpu_run_checker_pkg
// Purpose  : Shared types and constants for the CPU run checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_run_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_TIMEOUT  = 2'd1,
        FC_HANG     = 2'd2,
        FC_MISMATCH = 2'd3
    } fail_code_t;

    localparam logic MODE_ANY = 1'b0;
    localparam logic MODE_SEQ = 1'b1;

    // Index width for N entries, never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_run_checker_matcher.sv
// ============================================================================
// Module   : expect_matcher
// Purpose  : Compares a value against packed expected entries at or above a
//            minimum index; reports a hit and the lowest matching index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module expect_matcher #(
    parameter int DATA_W   = 32,
    parameter int N_EXPECT = 2,
    parameter int IDX_W    = 1
) (
    input  logic [DATA_W-1:0]          i_value,
    input  logic [N_EXPECT*DATA_W-1:0] i_expectVals,
    input  logic [IDX_W-1:0]           i_minIdx,
    output logic                       o_hit,
    output logic [IDX_W-1:0]           o_idx
);

    logic [N_EXPECT-1:0] w_eq;

    generate
        for (genvar gi = 0; gi < N_EXPECT; gi++) begin : g_entry
            assign w_eq[gi] = (i_expectVals[gi*DATA_W +: DATA_W] == i_value) &&
                              (IDX_W'(gi) >= i_minIdx);
        end
    endgenerate

    // Scan downwards so the lowest matching entry is the one left standing.
    always_comb begin
        o_hit = |w_eq;
        o_idx = '0;
        for (int i = N_EXPECT - 1; i >= 0; i--) begin
            if (w_eq[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_run_checker.sv
// ============================================================================
// Module   : cpu_run_checker
// Purpose  : Run monitor for the single-cycle CPU: PASS/FAIL against expected
//            register values with timeout and hang detection.
//            Optional X detection on imData/regData: CPU_RUN_CHECKER_X_DETECT_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_run_checker
    import cpu_run_checker_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int N_EXPECT    = 2,
    parameter int TIMEOUT     = 1000,
    parameter int STALL_LIMIT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          mode,
    input  logic [N_EXPECT*DATA_W-1:0]    expect_vals,
    input  logic [DATA_W-1:0]             imAddr,
    input  logic [DATA_W-1:0]             regData,
`ifdef CPU_RUN_CHECKER_X_DETECT_EN
    input  logic [DATA_W-1:0]             imData,
`endif
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [1:0]                    fail_code,
    output logic [idxWidth(N_EXPECT)-1:0] match_idx,
    output logic [CNT_W-1:0]              cycles
);

    localparam int IDX_W   = idxWidth(N_EXPECT);
    localparam int STALL_W = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [IDX_W-1:0]   c_lastIdx = IDX_W'(N_EXPECT - 1);
    localparam logic [CNT_W-1:0]   c_timeout = CNT_W'(TIMEOUT);
    localparam logic [STALL_W-1:0] c_stall   = STALL_W'(STALL_LIMIT);

    state_t             r_state, w_nextState;
    fail_code_t         r_failCode, w_failNext;
    logic               r_mode;
    logic [CNT_W-1:0]   r_cycles, w_cyclesNext;
    logic [STALL_W-1:0] r_stallCnt, w_stallNext;
    logic [IDX_W-1:0]   r_seqIdx, r_matchIdx, w_minIdx, w_hitIdx;
    logic [DATA_W-1:0]  r_prevReg, r_prevAddr;
    logic               w_hit, w_newVal, w_seqAdv;
    logic               w_passEv, w_mismatchEv, w_hangEv, w_timeoutEv, w_xEv;

    // In sequence mode only entries not yet consumed are candidates.
    assign w_minIdx = (r_mode == MODE_SEQ) ? r_seqIdx : '0;

    expect_matcher #(
        .DATA_W   (DATA_W),
        .N_EXPECT (N_EXPECT),
        .IDX_W    (IDX_W)
    ) u_matcher (
        .i_value      (regData),
        .i_expectVals (expect_vals),
        .i_minIdx     (w_minIdx),
        .o_hit        (w_hit),
        .o_idx        (w_hitIdx)
    );

`ifdef CPU_RUN_CHECKER_X_DETECT_EN
    assign w_xEv = $isunknown(imData) || $isunknown(regData);
`else
    assign w_xEv = 1'b0;
`endif

    always_comb begin
        w_cyclesNext = (r_cycles == '1) ? r_cycles : r_cycles + 1'b1;
        w_stallNext  = '0;
        if (imAddr == r_prevAddr) begin
            w_stallNext = (r_stallCnt == '1) ? r_stallCnt : r_stallCnt + 1'b1;
        end
        // The first RUN cycle (cycles still 0) only primes r_prevReg.
        w_newVal     = (r_cycles != '0) && (regData != r_prevReg);
        w_seqAdv     = (r_mode == MODE_SEQ) && w_newVal && w_hit && (w_hitIdx == r_seqIdx);
        w_passEv     = (r_mode == MODE_ANY) ? w_hit : (w_seqAdv && (r_seqIdx == c_lastIdx));
        w_mismatchEv = (r_mode == MODE_SEQ) && w_newVal && !w_hit;
        w_hangEv     = (STALL_LIMIT != 0) && (w_stallNext == c_stall);
        w_timeoutEv  = (w_cyclesNext == c_timeout);
    end

    always_comb begin
        w_nextState = r_state;
        w_failNext  = r_failCode;
        if (start) begin
            w_nextState = ST_RUN;
            w_failNext  = FC_NONE;
        end else if (r_state == ST_RUN) begin
            if (w_xEv) begin
                w_nextState = ST_FAIL;
                w_failNext  = FC_MISMATCH;
            end else if (w_passEv) begin
                w_nextState = ST_PASS;
            end else if (w_mismatchEv) begin
                w_nextState = ST_FAIL;
                w_failNext  = FC_MISMATCH;
            end else if (w_hangEv) begin
                w_nextState = ST_FAIL;
                w_failNext  = FC_HANG;
            end else if (w_timeoutEv) begin
                w_nextState = ST_FAIL;
                w_failNext  = FC_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_failCode <= FC_NONE;
        end else begin
            r_state    <= w_nextState;
            r_failCode <= w_failNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode     <= MODE_ANY;
            r_cycles   <= '0;
            r_stallCnt <= '0;
            r_seqIdx   <= '0;
            r_matchIdx <= '0;
            r_prevReg  <= '0;
            r_prevAddr <= '0;
        end else begin
            r_prevAddr <= imAddr;
            if (start) begin
                r_mode     <= mode;
                r_cycles   <= '0;
                r_stallCnt <= '0;
                r_seqIdx   <= '0;
                r_matchIdx <= '0;
            end else if (r_state == ST_RUN) begin
                r_cycles   <= w_cyclesNext;
                r_stallCnt <= w_stallNext;
                r_prevReg  <= regData;
                if (!w_xEv) begin
                    if (r_mode == MODE_ANY && w_passEv) begin
                        r_matchIdx <= w_hitIdx;
                    end
                    if (w_seqAdv) begin
                        r_matchIdx <= r_seqIdx;
                        if (r_seqIdx != c_lastIdx) begin
                            r_seqIdx <= r_seqIdx + 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef CPU_RUN_CHECKER_X_DETECT_EN
    always @(posedge clk) begin
        if (rst_n && !start && r_state == ST_RUN && w_xEv) begin
            $display("cpu_run_checker: unknown imData/regData at imAddr 0x%h", imAddr);
        end
    end
`endif

    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_PASS) || (r_state == ST_FAIL);
    assign pass      = (r_state == ST_PASS);
    assign fail_code = r_failCode;
    assign match_idx = r_matchIdx;
    assign cycles    = r_cycles;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_checker.sv
// ============================================================================
// Module   : tb_cpu_run_checker
// Purpose  : Self-checking bench for cpu_run_checker with a trace-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_run_checker;

    localparam int DW   = 32;
    localparam int NE   = 3;
    localparam int TMO  = 100;
    localparam int SL   = 16;
    localparam int CW   = 16;
    localparam int MAXC = 110;

    logic            clk = 1'b0;
    logic            rst_n, start, mode;
    logic [NE*DW-1:0] expect_vals;
    logic [DW-1:0]   imAddr, regData;
`ifdef CPU_RUN_CHECKER_X_DETECT_EN
    logic [DW-1:0]   imData;
`endif
    logic            busy, done, pass;
    logic [1:0]      fail_code, match_idx;
    logic [CW-1:0]   cycles;

    // Trace index 0 is the start edge; index t is the value seen at RUN edge t.
    logic [DW-1:0] addrTr [0:MAXC];
    logic [DW-1:0] regTr  [0:MAXC];
    logic [DW-1:0] expv   [0:NE-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_run_checker #(
        .DATA_W      (DW),
        .N_EXPECT    (NE),
        .TIMEOUT     (TMO),
        .STALL_LIMIT (SL),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .expect_vals (expect_vals),
        .imAddr      (imAddr),
        .regData     (regData),
`ifdef CPU_RUN_CHECKER_X_DETECT_EN
        .imData      (imData),
`endif
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail_code   (fail_code),
        .match_idx   (match_idx),
        .cycles      (cycles)
    );

    task automatic set_expect();
        for (int i = 0; i < NE; i++) expect_vals[i*DW +: DW] = expv[i];
    endtask

    // Plays the trace from a start pulse; returns the RUN edge at which done rose (-1 if never).
    task automatic run_trace(input logic m, output int doneAt);
        @(negedge clk);
        set_expect();
        mode = m; start = 1'b1; imAddr = addrTr[0]; regData = regTr[0];
        @(negedge clk);
        start = 1'b0;
        doneAt = -1;
        for (int t = 1; t <= MAXC; t++) begin
            imAddr = addrTr[t]; regData = regTr[t];
            @(posedge clk); #1;
            if (done) begin
                doneAt = t;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Outcome derived from the trace: first decisive edge, with PASS > MISMATCH > HANG > TIMEOUT.
    function automatic void model(input logic m, output int k, output bit p,
                                  output int code, output int idx);
        int run = 0;
        int nxt = 0;
        k = -1; p = 0; code = 0; idx = 0;
        for (int t = 1; t <= MAXC; t++) begin
            bit isPass = 0, isMis = 0;
            int found = -1;
            run = (addrTr[t] == addrTr[t-1]) ? run + 1 : 0;
            if (m == 1'b0) begin
                for (int i = NE - 1; i >= 0; i--) if (regTr[t] == expv[i]) found = i;
                if (found >= 0) begin isPass = 1; idx = found; end
            end else if (t >= 2 && regTr[t] != regTr[t-1]) begin
                for (int i = NE - 1; i >= nxt; i--) if (regTr[t] == expv[i]) found = i;
                if (found < 0) isMis = 1;
                else if (found == nxt) begin
                    idx = nxt; nxt++;
                    if (nxt == NE) isPass = 1;
                end
            end
            if (isPass)         begin k = t; p = 1; code = 0; return; end
            else if (isMis)     begin k = t; code = 3; return; end
            else if (run == SL) begin k = t; code = 2; return; end
            else if (t == TMO)  begin k = t; code = 1; return; end
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; expect_vals = '0;
        imAddr = '0; regData = '0;
`ifdef CPU_RUN_CHECKER_X_DETECT_EN
        imData = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0)       begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (pass !== 1'b0)       begin bad++; $display("FAIL reset_pass got=%b exp=0", pass); end
        total++; if (fail_code !== 2'd0)  begin bad++; $display("FAIL reset_fail_code got=%0d exp=0", fail_code); end
        total++; if (match_idx !== 2'd0)  begin bad++; $display("FAIL reset_match_idx got=%0d exp=0", match_idx); end
        total++; if (cycles !== 16'd0)    begin bad++; $display("FAIL reset_cycles got=%0d exp=0", cycles); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_match_any();
        int d;
        expv[0] = 32'h00213d05; expv[1] = 32'h1c8cfc00; expv[2] = 32'hdeadbeef;
        for (int t = 0; t <= MAXC; t++) begin
            addrTr[t] = 32'(t * 4);
            regTr[t]  = (t <= 1) ? 32'd0 : (t == 2) ? 32'd1 : 32'd2;
        end
        regTr[40] = 32'h1c8cfc00;
        run_trace(1'b0, d);
        total++; if (d != 40)            begin bad++; $display("FAIL any_done_edge got=%0d exp=40", d); end
        total++; if (pass !== 1'b1)      begin bad++; $display("FAIL any_pass got=%b exp=1", pass); end
        total++; if (match_idx !== 2'd1) begin bad++; $display("FAIL any_match_idx got=%0d exp=1", match_idx); end
        total++; if (cycles !== 16'd40)  begin bad++; $display("FAIL any_cycles got=%0d exp=40", cycles); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL any_busy got=%b exp=0", busy); end
    endtask

    task automatic test_match_seq();
        int d;
        expv[0] = 32'd1; expv[1] = 32'd2; expv[2] = 32'd6;
        for (int t = 0; t <= MAXC; t++) begin
            addrTr[t] = 32'(t * 4);
            regTr[t]  = (t <= 5) ? 32'd0 : (t <= 10) ? 32'd1 : (t <= 15) ? 32'd2 : 32'd6;
        end
        run_trace(1'b1, d);
        total++; if (d != 16)            begin bad++; $display("FAIL seq_done_edge got=%0d exp=16", d); end
        total++; if (pass !== 1'b1)      begin bad++; $display("FAIL seq_pass got=%b exp=1", pass); end
        total++; if (match_idx !== 2'd2) begin bad++; $display("FAIL seq_match_idx got=%0d exp=2", match_idx); end
        total++; if (cycles !== 16'd16)  begin bad++; $display("FAIL seq_cycles got=%0d exp=16", cycles); end
        for (int t = 0; t <= MAXC; t++)
            regTr[t] = (t <= 5) ? 32'd0 : (t <= 11) ? 32'd1 : 32'd3;
        run_trace(1'b1, d);
        total++; if (d != 12)            begin bad++; $display("FAIL seqmis_done_edge got=%0d exp=12", d); end
        total++; if (fail_code !== 2'd3) begin bad++; $display("FAIL seqmis_fail_code got=%0d exp=3", fail_code); end
        total++; if (pass !== 1'b0)      begin bad++; $display("FAIL seqmis_pass got=%b exp=0", pass); end
        total++; if (match_idx !== 2'd0) begin bad++; $display("FAIL seqmis_match_idx got=%0d exp=0", match_idx); end
    endtask

    task automatic test_timeout();
        int d;
        expv[0] = 32'h11; expv[1] = 32'h22; expv[2] = 32'h33;
        for (int t = 0; t <= MAXC; t++) begin
            addrTr[t] = 32'(t * 4);
            regTr[t]  = 32'h55;
        end
        run_trace(1'b0, d);
        total++; if (d != TMO)           begin bad++; $display("FAIL timeout_done_edge got=%0d exp=%0d", d, TMO); end
        total++; if (fail_code !== 2'd1) begin bad++; $display("FAIL timeout_fail_code got=%0d exp=1", fail_code); end
        total++; if (cycles !== 16'(TMO)) begin bad++; $display("FAIL timeout_cycles got=%0d exp=%0d", cycles, TMO); end
        total++; if (pass !== 1'b0)      begin bad++; $display("FAIL timeout_pass got=%b exp=0", pass); end
    endtask

    task automatic test_hang();
        int d;
        expv[0] = 32'h11; expv[1] = 32'h22; expv[2] = 32'h33;
        for (int t = 0; t <= MAXC; t++) begin
            addrTr[t] = 32'h40;
            regTr[t]  = 32'h55;
        end
        run_trace(1'b0, d);
        total++; if (d != SL)            begin bad++; $display("FAIL hang_done_edge got=%0d exp=%0d", d, SL); end
        total++; if (fail_code !== 2'd2) begin bad++; $display("FAIL hang_fail_code got=%0d exp=2", fail_code); end
        regTr[SL] = 32'h22;
        run_trace(1'b0, d);
        total++; if (d != SL)            begin bad++; $display("FAIL hangpass_done_edge got=%0d exp=%0d", d, SL); end
        total++; if (pass !== 1'b1)      begin bad++; $display("FAIL hangpass_pass got=%b exp=1", pass); end
        total++; if (fail_code !== 2'd0) begin bad++; $display("FAIL hangpass_fail_code got=%0d exp=0", fail_code); end
    endtask

    task automatic test_random();
        int d, ek, ecode, eidx, ptr, hold, freeze;
        bit ep;
        logic m;
        logic [DW-1:0] v, a;
        for (int r = 0; r < 24; r++) begin
            m = 1'($urandom_range(0, 1));
            for (int i = 0; i < NE; i++) expv[i] = 32'($urandom_range(0, 63));
            ptr = 0; hold = 0; freeze = 0; v = 32'd100; a = 32'h1000;
            for (int t = 0; t <= MAXC; t++) begin
                if (hold == 0) begin
                    hold = $urandom_range(1, 4);
                    if (m && $urandom_range(0, 3) != 0) begin
                        v = expv[ptr % NE]; ptr++;
                    end else begin
                        v = 32'($urandom_range(0, 63));
                    end
                end
                hold--;
                if (freeze > 0) freeze--;
                else if ($urandom_range(0, 15) == 0) freeze = $urandom_range(5, 20);
                else a = a + 32'd4;
                addrTr[t] = a; regTr[t] = v;
            end
            model(m, ek, ep, ecode, eidx);
            run_trace(m, d);
            total++;
            if (d != ek || pass !== ep || fail_code !== 2'(ecode) ||
                match_idx !== 2'(eidx) || cycles !== 16'(ek)) begin
                bad++;
                $display("FAIL rand_run%0d mode=%0d got edge=%0d pass=%b code=%0d idx=%0d cyc=%0d exp edge=%0d pass=%0d code=%0d idx=%0d",
                         r, m, d, pass, fail_code, match_idx, cycles, ek, ep, ecode, eidx);
            end
        end
    endtask

    task automatic test_restart();
        int d;
        expv[0] = 32'd1; expv[1] = 32'd2; expv[2] = 32'd6;
        for (int t = 0; t <= MAXC; t++) begin
            addrTr[t] = 32'(t * 4);
            regTr[t]  = (t <= 5) ? 32'd0 : (t <= 11) ? 32'd1 : 32'd3;
        end
        run_trace(1'b1, d);
        total++; if (fail_code !== 2'd3) begin bad++; $display("FAIL restart_pre_fail got=%0d exp=3", fail_code); end
        @(negedge clk);
        start = 1'b1; mode = 1'b0; imAddr = 32'h200;
        @(posedge clk); #1;
        total++; if (busy !== 1'b1)      begin bad++; $display("FAIL restart_busy got=%b exp=1", busy); end
        total++; if (cycles !== 16'd0)   begin bad++; $display("FAIL restart_cycles got=%0d exp=0", cycles); end
        total++; if (fail_code !== 2'd0) begin bad++; $display("FAIL restart_fail_code got=%0d exp=0", fail_code); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL restart_done got=%b exp=0", done); end
        @(negedge clk);
        start = 1'b0; regData = 32'h55;
        for (int i = 0; i < 5; i++) begin
            imAddr = imAddr + 32'd4;
            @(negedge clk);
        end
        total++; if (cycles !== 16'd5)   begin bad++; $display("FAIL run_cycles got=%0d exp=5", cycles); end
        start = 1'b1;
        @(posedge clk); #1;
        total++; if (cycles !== 16'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL midrun_restart got cycles=%0d busy=%b exp cycles=0 busy=1", cycles, busy);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin imAddr = imAddr + 32'd4; @(negedge clk); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if ({busy, done, pass, fail_code, match_idx} !== 7'd0 || cycles !== 16'd0) begin
            bad++; $display("FAIL async_reset got busy=%b done=%b pass=%b code=%0d idx=%0d cyc=%0d exp all 0",
                            busy, done, pass, fail_code, match_idx, cycles);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef CPU_RUN_CHECKER_X_DETECT_EN
    task automatic test_x_detect();
        expv[0] = 32'h11; expv[1] = 32'h22; expv[2] = 32'h33;
        @(negedge clk);
        set_expect();
        imData = '0; mode = 1'b0; start = 1'b1; imAddr = 32'h80; regData = 32'h55;
        @(negedge clk);
        start = 1'b0; imAddr = 32'h84;
        @(negedge clk);
        imData = 'x; imAddr = 32'h88;
        @(posedge clk); #1;
        total++; if (fail_code !== 2'd3 || done !== 1'b1) begin
            bad++; $display("FAIL xdetect got code=%0d done=%b exp code=3 done=1", fail_code, done);
        end
        imData = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_match_any();
        test_match_seq();
        test_timeout();
        test_hang();
        test_random();
        test_restart();
`ifdef CPU_RUN_CHECKER_X_DETECT_EN
        test_x_detect();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
